prbs_checker: RTL and testbench

PRBS_CHECKER -- requirements
Module: prbs_checker

---
 rtl/prbs_checker.sv | 142 ++++++++++++++
 tb/tb_prbs_checker.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/prbs_checker.sv
// PRBS7 (x^7 + x^6 + 1) sequence checker.
//
// Seeds a 7-bit history from the incoming stream, verifies that the stream
// self-predicts for LOCK_COUNT consecutive bits, then locks and free-runs a
// local generator. While locked, every valid bit is compared and counted.
// Too many errors inside one loss window drop back to seeding.
//
// Ports:
//   clk           rising-edge clock
//   rstn          asynchronous active-low reset
//   data_in       recovered bit under test
//   data_in_valid qualifies data_in, one bit per high cycle
//   clear         synchronous clear of bit_count, err_count, lock_lost
//   locked        high while in the locked state
//   bit_count     valid bits compared while locked (saturating)
//   err_count     mismatches while locked (saturating)
//   err_pulse     one-cycle pulse per locked mismatch
//   lock_lost     sticky, set when lock is lost
module prbs_checker #(
  parameter int unsigned LOCK_COUNT  = 64,
  parameter int unsigned LOSS_ERRS   = 8,
  parameter int unsigned LOSS_WINDOW = 128
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        data_in,
  input  logic        data_in_valid,
  input  logic        clear,
  output logic        locked,
  output logic [31:0] bit_count,
  output logic [31:0] err_count,
  output logic        err_pulse,
  output logic        lock_lost
);

  localparam int unsigned MW  = $clog2(LOCK_COUNT + 1);
  localparam int unsigned WBW = $clog2(LOSS_WINDOW + 1);
  localparam int unsigned WEW = $clog2(LOSS_ERRS + 1);

  localparam logic [MW-1:0]  LockLast = MW'(LOCK_COUNT - 1);
  localparam logic [WBW-1:0] WinLast  = WBW'(LOSS_WINDOW - 1);
  localparam logic [WEW-1:0] ErrLimit = WEW'(LOSS_ERRS);

  typedef enum logic [1:0] {StSeed, StVerify, StLocked} state_e;

  state_e         state_q;
  logic [6:0]     h_q;
  logic [2:0]     seed_cnt_q;
  logic [MW-1:0]  match_cnt_q;
  logic [WBW-1:0] win_bits_q;
  logic [WEW-1:0] win_errs_q;

  logic           predicted;
  logic           mismatch;
  logic [WEW-1:0] win_errs_inc;

  assign predicted    = h_q[5] ^ h_q[6];
  assign mismatch     = data_in ^ predicted;
  assign win_errs_inc = win_errs_q + WEW'(mismatch);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StSeed;
      h_q         <= '0;
      seed_cnt_q  <= '0;
      match_cnt_q <= '0;
      win_bits_q  <= '0;
      win_errs_q  <= '0;
      locked      <= 1'b0;
      bit_count   <= '0;
      err_count   <= '0;
      err_pulse   <= 1'b0;
      lock_lost   <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (data_in_valid) begin
        case (state_q)
          StSeed: begin
            h_q <= {h_q[5:0], data_in};
            if (seed_cnt_q == 3'd6) begin
              seed_cnt_q <= '0;
              state_q    <= StVerify;
            end else begin
              seed_cnt_q <= seed_cnt_q + 3'd1;
            end
          end
          StVerify: begin
            // Self-synchronous: the received bit feeds the history.
            h_q <= {h_q[5:0], data_in};
            if (!mismatch) begin
              if (match_cnt_q == LockLast) begin
                match_cnt_q <= '0;
                state_q     <= StLocked;
                locked      <= 1'b1;
                win_bits_q  <= '0;
                win_errs_q  <= '0;
              end else begin
                match_cnt_q <= match_cnt_q + MW'(1);
              end
            end else begin
              match_cnt_q <= '0;
              seed_cnt_q  <= '0;
              state_q     <= StSeed;
            end
          end
          StLocked: begin
            // Free-running: the prediction, not the received bit, feeds the history.
            h_q <= {h_q[5:0], predicted};
            if (bit_count != '1) bit_count <= bit_count + 32'd1;
            if (mismatch) begin
              err_pulse <= 1'b1;
              if (err_count != '1) err_count <= err_count + 32'd1;
            end
            // Error limit is checked before the window boundary so it wins a tie.
            if (win_errs_inc == ErrLimit) begin
              state_q    <= StSeed;
              locked     <= 1'b0;
              lock_lost  <= 1'b1;
              seed_cnt_q <= '0;
              win_bits_q <= '0;
              win_errs_q <= '0;
            end else if (win_bits_q == WinLast) begin
              win_bits_q <= '0;
              win_errs_q <= '0;
            end else begin
              win_bits_q <= win_bits_q + WBW'(1);
              win_errs_q <= win_errs_inc;
            end
          end
          default: state_q <= StSeed;
        endcase
      end
      // Clear overrides any counting done by this cycle's bit.
      if (clear) begin
        bit_count <= '0;
        err_count <= '0;
        lock_lost <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker: the driver pushes the expected output
// snapshot for every clock it drives; a negedge monitor pops and compares.
module tb_prbs_checker;

  logic        clk;
  logic        rstn;
  logic        data_in;
  logic        data_in_valid;
  logic        clear;
  logic        locked;
  logic [31:0] bit_count;
  logic [31:0] err_count;
  logic        err_pulse;
  logic        lock_lost;

  prbs_checker dut (
    .clk          (clk),
    .rstn         (rstn),
    .data_in      (data_in),
    .data_in_valid(data_in_valid),
    .clear        (clear),
    .locked       (locked),
    .bit_count    (bit_count),
    .err_count    (err_count),
    .err_pulse    (err_pulse),
    .lock_lost    (lock_lost)
  );

  typedef struct packed {
    logic        locked;
    logic [31:0] bits;
    logic [31:0] errs;
    logic        pulse;
    logic        lost;
  } exp_t;

  exp_t     q[$];
  exp_t     e;
  exp_t     mx;
  logic [6:0] g;
  int       lk_n;
  int       checks;
  int       errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      mx = q.pop_front();
      chk("locked", {31'd0, locked}, {31'd0, mx.locked});
      chk("bit_count", bit_count, mx.bits);
      chk("err_count", err_count, mx.errs);
      chk("err_pulse", {31'd0, err_pulse}, {31'd0, mx.pulse});
      chk("lock_lost", {31'd0, lock_lost}, {31'd0, mx.lost});
    end
  end

  // Next PRBS7 bit from the bench generator.
  task automatic gen(output logic b);
    b = g[5] ^ g[6];
    g = {g[5:0], b};
  endtask

  // Drive one cycle; e must already hold the outputs expected after this edge.
  task automatic step(input logic v, input logic d, input logic c);
    data_in       = d;
    data_in_valid = v;
    clear         = c;
    @(posedge clk);
    q.push_back(e);
    #1;
    data_in_valid = 1'b0;
    clear         = 1'b0;
  endtask

  task automatic idle();
    e.pulse = 1'b0;
    step(1'b0, 1'b0, 1'b0);
  endtask

  // n clean bits while not locked; locked rises with the last one.
  task automatic ubits(input int n, input bit gappy);
    logic b;
    for (int i = 0; i < n; i++) begin
      gen(b);
      e.locked = (i == n - 1);
      e.pulse  = 1'b0;
      step(1'b1, b, 1'b0);
      if (gappy) idle();
    end
    lk_n = 0;
  endtask

  // One bit while locked: optionally inverted, with clear, or the lock-losing error.
  task automatic lbit(input bit inv, input bit clr, input bit lose);
    logic b;
    gen(b);
    e.bits  = e.bits + 1;
    if (inv) e.errs = e.errs + 1;
    e.pulse = inv;
    if (lose) begin
      e.locked = 1'b0;
      e.lost   = 1'b1;
    end
    if (clr) begin
      e.bits = 0;
      e.errs = 0;
      e.lost = 1'b0;
    end
    lk_n++;
    step(1'b1, b ^ inv, clr);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    g             = 7'h7F;
    e             = '0;
    lk_n          = 0;
    rstn          = 1'b0;
    data_in       = 1'b0;
    data_in_valid = 1'b0;
    clear         = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // Reset state and an idle cycle.
    idle();
    idle();

    // Error-free lock: 7 seed + 64 verify bits, then 1000 clean locked bits.
    ubits(71, 1'b0);
    for (int i = 0; i < 1000; i++) lbit(1'b0, 1'b0, 1'b0);
    chk("clean_bit_count", bit_count, 32'd1000);
    chk("clean_err_count", err_count, 32'd0);

    // Single error: one-cycle pulse, lock kept.
    lbit(1'b1, 1'b0, 1'b0);
    lbit(1'b0, 1'b0, 1'b0);
    idle();
    chk("single_err_count", err_count, 32'd1);

    // Clear on a clean bit, then align to a loss-window boundary.
    lbit(1'b0, 1'b1, 1'b0);
    while (lk_n % 128 != 0) lbit(1'b0, 1'b0, 1'b0);
    chk("aligned_bit_count", bit_count, 32'd21);

    // Loss of lock: 8 errors spaced 10 apart inside one window.
    for (int k = 0; k < 8; k++) begin
      lbit(1'b1, 1'b0, k == 7);
      if (k != 7) for (int j = 0; j < 9; j++) lbit(1'b0, 1'b0, 1'b0);
    end
    idle();
    chk("loss_err_count", err_count, 32'd8);
    chk("loss_bit_count", bit_count, 32'd92);
    chk("loss_locked", {31'd0, locked}, 32'd0);

    // Relock with gappy valid; counts continue from the held values.
    ubits(71, 1'b1);
    for (int i = 0; i < 50; i++) begin
      lbit(1'b0, 1'b0, 1'b0);
      idle();
    end
    chk("gappy_bit_count", bit_count, 32'd142);

    // Clear together with an erroneous locked bit.
    lbit(1'b1, 1'b1, 1'b0);
    chk("clear_lock_lost", {31'd0, lock_lost}, 32'd0);
    for (int i = 0; i < 3; i++) lbit(1'b0, 1'b0, 1'b0);

    // Asynchronous reset while locked.
    @(negedge clk);
    #1 rstn = 1'b0;
    #1;
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_bit_count", bit_count, 32'd0);
    chk("rst_err_count", err_count, 32'd0);
    chk("rst_err_pulse", {31'd0, err_pulse}, 32'd0);
    chk("rst_lock_lost", {31'd0, lock_lost}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    e = '0;

    // First valid bit after reset is seed bit 0.
    ubits(71, 1'b0);
    for (int i = 0; i < 5; i++) lbit(1'b0, 1'b0, 1'b0);
    chk("post_rst_bit_count", bit_count, 32'd5);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
